// File: rtl/dsc_mul_n.sv
// Deterministic stochastic-computing multiplier: N unary clock-division streams ANDed and counted.
// Optional DSC_EARLY_STOP_EN ends each run once the slowest field reaches its operand.
module dsc_mul_n #(
  parameter int unsigned SNG_WIDTH  = 4,
  parameter int unsigned NUM_INPUTS = 3
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_en,
  input  logic                            i_start,
  input  logic [NUM_INPUTS*SNG_WIDTH-1:0] i_op_in,
  output logic [NUM_INPUTS*SNG_WIDTH-1:0] o_z,
  output logic                            o_busy,
  output logic                            o_done
);

  localparam int unsigned TotW   = NUM_INPUTS * SNG_WIDTH;
  localparam int unsigned TopLsb = (NUM_INPUTS - 1) * SNG_WIDTH;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e            r_state, w_state_d;
  logic [TotW-1:0]   r_cnt, w_cnt_d, w_cnt_inc;
  logic [TotW-1:0]   r_z, w_z_d;
  logic [TotW-1:0]   r_a, w_a_d;
  logic              r_busy, r_done;
  logic              w_p, w_last;

  // One shared counter: field i compared against operand i gives stream bit s_i.
  always_comb begin
    w_p = 1'b1;
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      if (!(r_cnt[i*SNG_WIDTH +: SNG_WIDTH] < r_a[i*SNG_WIDTH +: SNG_WIDTH])) begin
        w_p = 1'b0;
      end
    end
  end

  assign w_cnt_inc = r_cnt + {{(TotW-1){1'b0}}, 1'b1};

  always_comb begin
    w_last = (r_cnt == {TotW{1'b1}});
`ifdef DSC_EARLY_STOP_EN
    // Once the slowest field reaches its operand no further 1s can appear.
    if (w_cnt_inc[TopLsb +: SNG_WIDTH] == r_a[TopLsb +: SNG_WIDTH]) begin
      w_last = 1'b1;
    end
`endif
  end

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_z_d     = r_z;
    w_a_d     = r_a;
    case (r_state)
      StIdle: begin
        if (i_en && i_start) begin
          w_a_d     = i_op_in;
          w_cnt_d   = '0;
          w_z_d     = '0;
          w_state_d = StRun;
`ifdef DSC_EARLY_STOP_EN
          if (i_op_in[TopLsb +: SNG_WIDTH] == '0) begin
            w_state_d = StDone;
          end
`endif
        end
      end
      StRun: begin
        if (i_en) begin
          w_z_d   = r_z + {{(TotW-1){1'b0}}, w_p};
          w_cnt_d = w_cnt_inc;
          if (w_last) begin
            w_state_d = StDone;
          end
        end
      end
      StDone: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_z     <= '0;
      r_a     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_z     <= w_z_d;
      r_a     <= w_a_d;
      r_busy  <= (w_state_d == StRun);
      r_done  <= (w_state_d == StDone);
    end
  end

  assign o_z    = r_z;
  assign o_busy = r_busy;
  assign o_done = r_done;

endmodule

// File: tb/tb_dsc_mul_n.sv
// Bench for dsc_mul_n: product/latency model for the default instance plus a W=2,N=2 instance.
module tb_dsc_mul_n;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        start = 1'b0;
  logic [11:0] op = '0;
  logic [11:0] z;
  logic        busy, done;

  logic        start2 = 1'b0;
  logic        en2 = 1'b1;
  logic [3:0]  op2 = '0;
  logic [3:0]  z2;
  logic        busy2, done2;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  dsc_mul_n #(.SNG_WIDTH(4), .NUM_INPUTS(3)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_start(start), .i_op_in(op),
    .o_z(z), .o_busy(busy), .o_done(done)
  );

  dsc_mul_n #(.SNG_WIDTH(2), .NUM_INPUTS(2)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en2), .i_start(start2), .i_op_in(op2),
    .o_z(z2), .o_busy(busy2), .o_done(done2)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  function automatic longint prod3(input logic [11:0] a);
    return longint'(a[3:0]) * longint'(a[7:4]) * longint'(a[11:8]);
  endfunction

  function automatic int run_len3(input logic [11:0] a);
`ifdef DSC_EARLY_STOP_EN
    return int'(a[11:8]) * 256;
`else
    return 4096;
`endif
  endfunction

  // Behavioural model of the default instance: mode 0 idle, 1 run, 2 done.
  int     m_mode = 0;
  int     m_rem = 0;
  longint m_target = 0;
  longint m_z = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode   <= 0;
      m_rem    <= 0;
      m_target <= 0;
      m_z      <= 0;
    end else begin
      case (m_mode)
        0: if (en && start) begin
          m_target <= prod3(op);
          m_rem    <= run_len3(op);
          m_mode   <= (run_len3(op) == 0) ? 2 : 1;
          m_z      <= (run_len3(op) == 0) ? prod3(op) : m_z;
        end
        1: if (en) begin
          m_rem <= m_rem - 1;
          if (m_rem == 1) begin
            m_mode <= 2;
            m_z    <= m_target;
          end
        end
        default: m_mode <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("busy", busy, (m_mode == 1) ? 1 : 0);
      chk("done", done, (m_mode == 2) ? 1 : 0);
      if (m_mode != 1) chk("z_hold", z, m_z);
      else chk("z_bound", (longint'(z) <= m_target) ? 1 : 0, 1);
    end
  end

  task automatic run_main(input string tag, input logic [11:0] a, input bit stall,
                          input longint exp_z, input int exp_busy);
    int nb;
    int cyc;
    @(negedge clk);
    op = a;
    start = 1'b1;
    en = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nb = 0;
    cyc = 0;
    while (!done && cyc < 20000) begin
      if (busy) nb++;
      cyc++;
      if (stall) begin
        en = (nb % 2 == 0);
        start = (nb % 3 == 1);
        op = 12'($urandom);
      end
      @(negedge clk);
    end
    en = 1'b1;
    start = 1'b0;
    chk({tag, "_done_seen"}, done, 1);
    chk({tag, "_z"}, z, exp_z);
    chk({tag, "_busy_cycles"}, nb, exp_busy);
    @(negedge clk);
    chk({tag, "_done_width"}, done, 0);
    chk({tag, "_z_stable"}, z, exp_z);
  endtask

  task automatic run_small(input string tag, input logic [3:0] a);
    int nb;
    int cyc;
    int inc;
    logic [3:0] prev;
    int exp_z;
    int exp_l;
    exp_z = int'(a[1:0]) * int'(a[3:2]);
`ifdef DSC_EARLY_STOP_EN
    exp_l = int'(a[3:2]) * 4;
`else
    exp_l = 16;
`endif
    @(negedge clk);
    op2 = a;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    op2 = 4'($urandom);
    nb = 0;
    cyc = 0;
    inc = 0;
    prev = z2;
    while (!done2 && cyc < 100) begin
      if (busy2) nb++;
      cyc++;
      @(negedge clk);
      if (z2 != prev) inc++;
      prev = z2;
    end
    chk({tag, "_done_seen"}, done2, 1);
    chk({tag, "_z"}, z2, exp_z);
    chk({tag, "_len"}, nb, exp_l);
    chk({tag, "_incs"}, inc, exp_z);
    repeat (2) begin
      @(negedge clk);
      chk({tag, "_done_width"}, done2, 0);
      chk({tag, "_z_stable"}, z2, exp_z);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_z", z, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_z2", z2, 0);
    rst_n = 1'b1;
    chk_on = 1'b1;

`ifdef DSC_EARLY_STOP_EN
    run_main("all15", 12'hFFF, 1'b0, 3375, 3840);
    run_main("a2zero", 12'h035, 1'b0, 0, 0);
    run_main("stall", 12'hB97, 1'b1, 693, 5632);
`else
    run_main("all15", 12'hFFF, 1'b0, 3375, 4096);
    run_main("a2zero", 12'h035, 1'b0, 0, 4096);
    run_main("stall", 12'hB97, 1'b1, 693, 8192);
`endif

    // Abort a run at cycle 100 with an asynchronous reset.
    @(negedge clk);
    op = 12'hFFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (99) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_z", z, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_done", done, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
`ifdef DSC_EARLY_STOP_EN
    run_main("ones", 12'h111, 1'b0, 1, 256);
`else
    run_main("ones", 12'h111, 1'b0, 1, 4096);
`endif

    run_small("w2_3x2", 4'hB);
    for (int i = 0; i < 200; i++) begin
      run_small("w2_rand", 4'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dsc_mul_n.md
# dsc_mul_n

Parametrised deterministic stochastic-computing (DSC) multiplier for N unsigned operands of SNG_WIDTH bits each, using clock-division unary streams.
- All SNGs run from one clock: a single N·SNG_WIDTH-bit counter is split into per-input fields, replacing ripple-clocked SNG chains.
- An AND of the streams is counted into an exact binary product.
- Start/busy/done handshake, stall enable, and an optional early-stop path.
- Sits between the binary operand registers and downstream logic in the DSC datapath.

## Interface
- SNG_WIDTH, 4, bits per operand and per counter field
- NUM_INPUTS, 3, number of operands (≥2)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- en  in  1  global enable; 0 freezes all state (stall)
- start  in  1  request; sampled only in IDLE with en=1
- op_in  in  NUM_INPUTS·SNG_WIDTH  operand i at bits [i·SNG_WIDTH +: SNG_WIDTH]
- z  out  NUM_INPUTS·SNG_WIDTH  accumulated product; final value held until next accepted start
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse in DONE

## Operation
Let W=SNG_WIDTH, N=NUM_INPUTS, M=2^(N·W)−1, and cnt = N·W-bit run counter.
- Field i: cnt_i = cnt[i·W +: W]. Field 0 is the fastest-changing field.
- Stream bit s_i = (cnt_i < a_i), where a_i is the latched operand i.
- Product bit p = AND of all s_i.

States:
- IDLE
  - busy=0, done=0.
  - On start=1 and en=1: latch op_in into a_0..a_{N−1}, set cnt=0, set z=0, go to RUN.
  - Exception (DSC_EARLY_STOP_EN only): if a_{N−1}=0, go directly to DONE with z=0.
- RUN, each cycle with en=1:
  - z += p; cnt += 1.
  - Go to DONE when cnt==M (no wrap is carried forward).
  - DSC_EARLY_STOP_EN only: also go to DONE when cnt+1 has field N−1 equal to a_{N−1}.
- RUN with en=0: cnt and z hold, state holds, busy stays 1.
- DONE: done=1 for one cycle, then go to IDLE unconditionally (en not required).

Result and input rules:
- Final z equals the product of a_0..a_{N−1} exactly. The maximum is (2^W−1)^N < 2^(N·W), so z never overflows.
- start is ignored in RUN and DONE.
- op_in is ignored outside the accepting IDLE cycle; changing it mid-run has no effect.

Reset:
- rst=0 at any time forces IDLE, with cnt=0, z=0, busy=0, done=0, and all a_i=0.
- A run interrupted by reset is discarded.

## Timing
Start and run:
- The start is accepted at edge k. busy rises after edge k.
- Let L = the number of RUN cycles with en=1.
- done is high in the cycle after the last RUN cycle. z is final in that same cycle.
- busy and done are never high together.

Run length L:
- Without the macro: L = 2^(N·W). With defaults this is 4096.
- With the macro: L = a_{N−1}·2^((N−1)·W). For a_{N−1}=0, done is high in the cycle after acceptance.

Other rules:
- Stall cycles (en=0) add to latency 1:1.
- Back-to-back operation: the earliest next start is in the IDLE cycle after done.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- DSC_EARLY_STOP_EN defined:
  - RUN ends as soon as the slowest field (N−1) reaches a_{N−1}, after which no further 1s can occur.
  - a_{N−1}=0 skips RUN.
- DSC_EARLY_STOP_EN undefined:
  - Every run is the full 2^(N·W) cycles. This gives fixed, data-independent latency.
- z is identical in both builds for all operands.

## Test plan
- Defaults, op_in = {15,15,15}, en=1:
  - z=3375 on done.
  - busy high 4096 cycles without the macro; 3840 with it.
- Defaults, a_0=5, a_1=3, a_2=0:
  - z=0 in both builds.
  - Without the macro, busy lasts 4096 cycles.
  - With the macro, done is high in the cycle after acceptance and busy never rises.
- W=2, N=2, a_0=3, a_1=2:
  - z=6.
  - With the macro, L=8, and busy cycles with z increments total 6.
  - Without the macro, L=16.
- Defaults, a={7,9,11}, en toggled 0/1 every other cycle during RUN:
  - z=693.
  - The busy period is twice the unstalled length.
  - start pulses during RUN are ignored and z is unaffected.
- Reset at RUN cycle 100, then start with a={1,1,1}:
  - Immediately on rst=0: z=0, busy=0, done=0.
  - The new run yields z=1.
  - With the macro, L=256.
- Random operand sweep (≥200 vectors, both builds):
  - z equals the reference product on every done.
  - done is exactly one cycle wide.
  - z is stable until the next accepted start.
